// File: rtl/instruction_rom_bank_pkg.sv
// Shared types and constants for the instruction ROM bank: FSM states,
// fault bit positions, and the default word returned on a faulted fetch.
package instruction_rom_bank_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  // Fault flags for a byte address into a DEPTH-word array.
  function automatic logic [1:0] addr_fault(input logic [31:0] addr, input int depth);
    logic [1:0] f;
    f                 = '0;
    f[FAULT_MISALIGN] = |addr[1:0];
    f[FAULT_RANGE]    = (addr[31:2] >= 30'(depth));
    return f;
  endfunction

endpackage

// File: rtl/imem_sram_1r1w.sv
// Word array with one synchronous read port and one synchronous write port.
// A read and write to the same index in one cycle returns the old word.
module imem_sram_1r1w #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The array itself has no reset; only the read register does.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/instruction_rom_bank.sv
// Instruction fetch memory with a program-load port and a clear sweep.
// Fetches return one cycle after acceptance; faulted fetches return NOP_WORD.
module instruction_rom_bank
  import instruction_rom_bank_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 128,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [31:0]       rd_addr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [1:0]        rsp_fault,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy,
  output state_e            dbg_state
);

  localparam int AW = $clog2(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready depends only on state and clear, never on valid, and
  // clear withdraws ready so a clear pulse always wins over traffic.

  state_e            state, state_nxt;
  logic [AW-1:0]     cnt, cnt_nxt;
  logic              rd_fire, ld_fire;
  logic [1:0]        rd_flt, ld_flt;
  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] sram_rd_data;

  assign rd_flt  = addr_fault(rd_addr, DEPTH);
  assign ld_flt  = addr_fault(ld_addr, DEPTH);
  assign rd_fire = rd_valid & rd_ready;
  assign ld_fire = ld_valid & ld_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    rd_ready  = 1'b0;
    ld_ready  = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = ld_addr[AW+1:2];
    wr_data   = ld_data;
    case (state)
      CLEAR: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_idx  = cnt;
        wr_data = '0;
        if (clear) begin
          cnt_nxt = '0;
        end else if (cnt == AW'(DEPTH - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      IDLE: begin
        rd_ready = ~clear;
        ld_ready = ~clear;
        wr_en    = ld_fire & (ld_flt == 2'b00);
        if (clear) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  imem_sram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_sram (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_en   (rd_fire),
    .rd_idx  (rd_addr[AW+1:2]),
    .rd_data (sram_rd_data),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data)
  );

  // Fault flags only change on an accepted fetch, so the output holds with them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_fault <= 2'b00;
    end else begin
      rsp_valid <= rd_fire;
      if (rd_fire) rsp_fault <= rd_flt;
    end
  end

  assign rsp_instr = (rsp_fault != 2'b00) ? NOP_WORD : sram_rd_data;

endmodule

// File: tb/tb_instruction_rom_bank.sv
// Directed bench for instruction_rom_bank: sweep timing, load/fetch, faults,
// read-before-write, clear during traffic and reset mid-sweep.
module tb_instruction_rom_bank;
  import instruction_rom_bank_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_addr;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic [1:0]  rsp_fault;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        busy;
  state_e      dbg_state;

  int errors = 0;
  int checks = 0;

  instruction_rom_bank dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_instr (rsp_instr),
    .rsp_fault (rsp_fault),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count cycles until busy drops, bounded.
  task automatic count_busy(output int n, output bit saw_rsp);
    n = 0;
    saw_rsp = 1'b0;
    while (busy && n < 1000) begin
      step();
      n++;
      if (rsp_valid) saw_rsp = 1'b1;
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp_i,
                          input logic [1:0] exp_f, input string name);
    rd_valid = 1'b1;
    rd_addr  = a;
    step();
    rd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_instr !== exp_i || rsp_fault !== exp_f) begin
      errors++;
      $display("FAIL %s: got valid=%b instr=%h fault=%b, want valid=1 instr=%h fault=%b",
               name, rsp_valid, rsp_instr, rsp_fault, exp_i, exp_f);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (busy !== 1'b1 || rd_ready !== 1'b0 || ld_ready !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_instr !== 32'h0 || rsp_fault !== 2'b00 || dbg_state !== CLEAR) begin
      errors++;
      $display("FAIL %s: got busy=%b rd_ready=%b ld_ready=%b rsp_valid=%b instr=%h fault=%b, want 1 0 0 0 00000000 00",
               name, busy, rd_ready, ld_ready, rsp_valid, rsp_instr, rsp_fault);
    end
  endtask

  task automatic check_sweep(input string name);
    int  n;
    bit  saw;
    count_busy(n, saw);
    checks++;
    if (n !== 128 || saw) begin
      errors++;
      $display("FAIL %s: got busy cycles=%0d rsp_seen=%b, want 128 0", name, n, saw);
    end
    checks++;
    if (rd_ready !== 1'b1 || ld_ready !== 1'b1 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL %s_ready: got rd_ready=%b ld_ready=%b state=%b, want 1 1 IDLE",
               name, rd_ready, ld_ready, dbg_state);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b1;
    clear    = 1'b0;
    rd_valid = 1'b0;
    rd_addr  = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    #3 reset_n = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset_values");
    reset_n = 1'b1;
    check_sweep("reset_sweep");
    do_fetch(32'h40, 32'h0, 2'b00, "fetch_0x40_after_sweep");
  endtask

  task automatic test_load_fetch();
    do_load(32'h10, 32'hDEAD_BEEF);
    do_fetch(32'h10, 32'hDEAD_BEEF, 2'b00, "fetch_loaded_0x10");
    step();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_instr !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rsp_hold: got valid=%b instr=%h, want valid=0 instr=deadbeef",
               rsp_valid, rsp_instr);
    end
  endtask

  task automatic test_faults();
    do_fetch(32'h12, 32'h13, 2'b01, "fault_misaligned");
    do_fetch(32'h200, 32'h13, 2'b10, "fault_range");
    do_fetch(32'h202, 32'h13, 2'b11, "fault_both");
    do_fetch(32'h1FC, 32'h0, 2'b00, "last_word_in_range");
  endtask

  task automatic test_rbw();
    do_load(32'h8, 32'hAAAA);
    ld_valid = 1'b1;
    ld_addr  = 32'h8;
    ld_data  = 32'h1234;
    do_fetch(32'h8, 32'hAAAA, 2'b00, "rbw_old_word");
    ld_valid = 1'b0;
    do_fetch(32'h8, 32'h1234, 2'b00, "rbw_new_word");
    do_load(32'h9, 32'h5555);
    do_load(32'h208, 32'h6666);
    do_fetch(32'h8, 32'h1234, 2'b00, "faulted_loads_dropped");
  endtask

  task automatic test_back_to_back_clear();
    do_fetch(32'h10, 32'hDEAD_BEEF, 2'b00, "b2b_fetch_0");
    do_fetch(32'h8, 32'h1234, 2'b00, "b2b_fetch_1");
    rd_valid = 1'b1;
    rd_addr  = 32'h10;
    clear    = 1'b1;
    step();
    rd_valid = 1'b0;
    clear    = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_priority: got rsp_valid=%b busy=%b, want 0 1", rsp_valid, busy);
    end
    check_sweep("clear_sweep");
    for (int i = 0; i < 128; i++) begin
      do_fetch(32'(i * 4), 32'h0, 2'b00, "cleared_word");
    end
  endtask

  task automatic test_reset_mid_sweep();
    do_load(32'h10, 32'hCAFE_F00D);
    do_fetch(32'h202, 32'h13, 2'b11, "pre_reset_fault");
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (50) step();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_sweep");
    step();
    reset_n = 1'b1;
    check_sweep("post_reset_sweep");
    do_fetch(32'h10, 32'h0, 2'b00, "fetch_after_reset_sweep");
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_faults();
    test_rbw();
    test_back_to_back_clear();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_rom_bank.md
INSTRUCTION_ROM_BANK -- requirements
Module: instruction_rom_bank

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the instruction word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 128, giving the number of words (power of two, at least 4).
REQ-003 The block SHALL have parameter NOP_WORD, default 32'h0000_0013, giving the word returned on a faulted read.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have reset_n, input, 1, an asynchronous active-low reset.
REQ-006 The block SHALL have clear, input, 1, a one-cycle pulse that requests zeroing of the whole array.
REQ-007 The block SHALL have rd_valid, input, 1, a fetch request strobe.
REQ-008 The block SHALL have rd_ready, output, 1, meaning a fetch request is accepted this cycle.
REQ-009 The block SHALL have rd_addr, input, 32, a byte address.
REQ-010 The block SHALL have rsp_valid, output, 1, meaning rsp_instr and rsp_fault are valid.
REQ-011 The block SHALL have rsp_instr, output, DATA_W, the fetched word.
REQ-012 The block SHALL have rsp_fault, output, 2, where bit0 flags a misaligned address and bit1 flags an out-of-range address.
REQ-013 The block SHALL have ld_valid, input, 1, a program-load write strobe.
REQ-014 The block SHALL have ld_ready, output, 1, meaning a program-load write is accepted this cycle.
REQ-015 The block SHALL have ld_addr, input, 32, the byte address of a program-load write.
REQ-016 The block SHALL have ld_data, input, DATA_W, the program-load write data.
REQ-017 The block SHALL have busy, output, 1, asserted while a clear sweep is in progress.

Function
REQ-018 The FSM SHALL have exactly two states: CLEAR, which sweeps the array, and IDLE, which serves fetch and load traffic.
REQ-019 On leaving reset, the FSM SHALL be in CLEAR with the sweep counter at 0.
REQ-020 In CLEAR, the block SHALL write 0 to word[counter] each cycle and increment the counter; after DEPTH cycles, when the counter equals DEPTH-1, the FSM SHALL move to IDLE.
REQ-021 In CLEAR: busy=1, rd_ready=0, ld_ready=0.
REQ-022 In IDLE: busy=0, rd_ready=1, ld_ready=1.
REQ-023 A clear pulse in IDLE SHALL move the FSM to CLEAR with the counter at 0 on the next cycle.
REQ-024 A clear pulse in CLEAR SHALL restart the counter at 0.
REQ-025 A clear pulse SHALL take priority over a rd or ld handshake in the same cycle; that rd or ld is not accepted.
REQ-026 The word index SHALL be addr[log2(DEPTH)+1:2].
REQ-027 A request SHALL be misaligned when addr[1:0] is not 0.
REQ-028 A request SHALL be out-of-range when addr[31:2] is at least DEPTH.
REQ-029 A fetch SHALL be accepted on rd_valid & rd_ready.
REQ-030 An accepted fetch SHALL produce rsp_valid=1 exactly one cycle later, with rsp_valid=0 in every other cycle; fetch throughput SHALL be one per cycle.
REQ-031 A non-faulted fetch SHALL return word[index] in rsp_instr with rsp_fault=0.
REQ-032 A faulted fetch SHALL return NOP_WORD with the corresponding rsp_fault bits set; both bits may be set together.
REQ-033 rsp_instr and rsp_fault SHALL hold their last values while rsp_valid=0.
REQ-034 A load SHALL be accepted on ld_valid & ld_ready and SHALL write ld_data to word[index] at that edge.
REQ-035 A misaligned or out-of-range load SHALL be dropped silently with no array change.
REQ-036 When a fetch and a load to the same index are accepted in the same cycle, the fetch SHALL return the old word (read-before-write).

Reset
REQ-037 Asserting reset_n low SHALL, asynchronously, set: FSM=CLEAR, counter=0, rsp_valid=0, rsp_instr=0, rsp_fault=0, busy=1, rd_ready=0, ld_ready=0.
REQ-038 Reset SHALL NOT touch the array; the array SHALL be zeroed by the CLEAR sweep that follows reset deassertion.
REQ-039 A reset asserted mid-sweep or mid-fetch SHALL abandon the operation; no rsp_valid pulse SHALL be produced for a fetch in flight.

Structure
REQ-040 A shared package SHALL hold the state enum (CLEAR, IDLE), the fault bit positions, and the default NOP_WORD constant.
REQ-041 The storage SHALL be one sub-module, imem_sram_1r1w, providing a synchronous read port and a synchronous write port; the sweep and the load share its write port through a mux.

Verification
REQ-042 The bench SHALL check: reset release -> busy=1 for exactly 128 cycles, then ready; a fetch of 0x40 -> rsp_instr=0.
REQ-043 The bench SHALL check: load 0x10 with 0xDEADBEEF, then fetch 0x10 -> one cycle later rsp_valid=1, rsp_instr=0xDEADBEEF, rsp_fault=0.
REQ-044 The bench SHALL check: fetch 0x12 -> rsp_instr=0x00000013, rsp_fault=01; fetch 0x200 -> rsp_fault=10; fetch 0x202 -> rsp_fault=11.
REQ-045 The bench SHALL check: a same-cycle load of 0x8 with 0x1234 and fetch of 0x8 (old word 0xAAAA) -> 0xAAAA returned; the next fetch returns 0x1234.
REQ-046 The bench SHALL check: clear during back-to-back fetches -> no rsp_valid in the pulse cycle, busy=1 for 128 cycles, and all words read back 0.
REQ-047 The bench SHALL check: reset_n pulled low 50 cycles into a sweep -> outputs take reset values immediately, and a full 128-cycle sweep follows release.
